// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and default frame shape.
package uart_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int OVERSAMPLE        = 16;
    localparam int DEF_DATA_BITS     = 8;
    localparam int DEF_STOP_BIT_TICK = 16;

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: frames one byte MSB first (start, DATA_BITS data, stop) on a 16x sample_tick.
// tx is registered from the next-state value, so each level change lands 1 clk after its tick.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int STOP_BIT_TICK = DEF_STOP_BIT_TICK
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int              BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [4:0]      LAST_OS   = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]      LAST_STOP = 5'(STOP_BIT_TICK - 1);
    localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);

    uart_state_t          state;
    logic [4:0]           tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        shreg    <= data_in;
                        tick_cnt <= '0;
                        state    <= ST_START;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (sample_tick) begin
                        if (tick_cnt == LAST_OS) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= ST_DATA;
                            tx       <= shreg[DATA_BITS-1];
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample_tick) begin
                        if (tick_cnt == LAST_OS) begin
                            tick_cnt <= '0;
                            shreg    <= {shreg[DATA_BITS-2:0], 1'b0};
                            // Last bit holds the counter rather than letting it overflow.
                            if (bit_cnt == LAST_BIT) begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                                tx      <= shreg[DATA_BITS-2];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (sample_tick) begin
                        if (tick_cnt == LAST_STOP) begin
                            tick_cnt <= '0;
                            state    <= ST_IDLE;
                            tx       <= 1'b1;
                            tx_busy  <= 1'b0;
                            tx_done  <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench: stimulus pushes expected bytes, a line-decoding monitor pops and compares.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic       tx_start2 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx, tx_busy, tx_done;
    logic       tx2, tx_busy2, tx_done2;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int frames_seen = 0;
    logic [7:0] exp_q[$];

    always #10 clk = ~clk;

    uart_transmitter #(.DATA_BITS(8), .STOP_BIT_TICK(16)) dut (
        .clk_50MHz(clk), .reset(rst_n), .sample_tick(sample_tick), .tx_start(tx_start),
        .data_in(data_in), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_transmitter #(.DATA_BITS(8), .STOP_BIT_TICK(32)) dut2 (
        .clk_50MHz(clk), .reset(rst_n), .sample_tick(sample_tick), .tx_start(tx_start2),
        .data_in(data_in), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (tx_done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (tx_done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Tick every 4 clk, driven on the falling edge.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    // Monitor: decodes frames off tx by counting ticks from the start-bit fall, sampling mid-bit.
    initial begin
        bit         act = 1'b0;
        int         mcnt = 0;
        logic [7:0] sh = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_done === 1'b1) done_cnt++;
            if (!rst_n) begin
                act = 1'b0;
            end else begin
                if (!act && tx === 1'b0) begin
                    act  = 1'b1;
                    mcnt = 0;
                end
                if (act && sample_tick) begin
                    mcnt++;
                    if (mcnt == 8) begin
                        check("start_bit", 32'(tx), 32'd0);
                    end else if (mcnt > 8 && mcnt <= 136 && ((mcnt - 8) % 16) == 0) begin
                        sh = {sh[6:0], tx};
                    end else if (mcnt == 152) begin
                        check("stop_bit", 32'(tx), 32'd1);
                        frames_seen++;
                        if (exp_q.size() == 0) check("unexpected_frame", 32'(sh), 32'hFFFF_FFFF);
                        else check("frame_byte", 32'(sh), 32'(exp_q.pop_front()));
                        act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        bit bad;
        int t;
        int pre;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_tx2", 32'(tx2), 32'd1);
        rst_n = 1'b1;

        // Idle for 10 bit times with no request
        bad = 1'b0;
        repeat (640) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check("idle_line", 32'(bad), 32'd0);
        check("idle_no_done", 32'(done_cnt), 32'd0);

        // Single frame 0xA5 with timing
        exp_q.push_back(8'hA5);
        data_in = 8'hA5; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_after_accept", 32'(tx_busy), 32'd1);
        check("start_low", 32'(tx), 32'd0);
        t = 0;
        while (tx_done !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_range("frame_len_clk", t, 637, 640);
        check("busy_clear_at_done", 32'(tx_busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(tx_done), 32'd0);
        repeat (8) @(negedge clk);
        check("done_cnt_a5", 32'(done_cnt), 32'd1);

        // Three sequential frames
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = (i == 0) ? 8'hF0 : (i == 1) ? 8'h55 : 8'h43;
            exp_q.push_back(b);
            data_in = b; tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            wait_done(2000);
            repeat (3) @(negedge clk);
        end

        // Request during DATA is ignored
        exp_q.push_back(8'h3C);
        data_in = 8'h3C; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4 * 16 * 3) @(negedge clk);
        data_in = 8'hFF; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        bad = 1'b0;
        t = 0;
        while (tx_done !== 1'b1 && t < 2000) begin
            if (tx_busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
            t++;
        end
        check("busy_hold", 32'(bad), 32'd0);
        repeat (200) @(negedge clk);
        check("no_second_frame_tx", 32'(tx), 32'd1);

        // Back-to-back frames with tx_start held
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        data_in = 8'h81; tx_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wait_done(2000);
        data_in = 8'h7E;
        @(negedge clk);
        check("b2b_start_low", 32'(tx), 32'd0);
        check("b2b_busy", 32'(tx_busy), 32'd1);
        tx_start = 1'b0;
        @(negedge clk);
        wait_done(2000);
        repeat (8) @(negedge clk);
        check("done_cnt_b2b", 32'(done_cnt), 32'd7);

        // Reset during bit 3 of 0x00
        data_in = 8'h00; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4 * (16 + 3 * 16 + 8)) @(negedge clk);
        pre = done_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (800) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check("midrst_quiet", 32'(bad), 32'd0);
        check("midrst_no_done", 32'(done_cnt), 32'(pre));

        // Two stop bits on the STOP_BIT_TICK=32 instance
        data_in = 8'h00; tx_start2 = 1'b1;
        @(negedge clk);
        tx_start2 = 1'b0;
        t = 0;
        while (tx2 !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("stop32_rise_seen", 32'(tx2), 32'd1);
        t = 0;
        while (tx_done2 !== 1'b1 && t < 2000) begin
            if (tx2 !== 1'b1) bad = 1'b1;
            @(negedge clk);
            t++;
        end
        check("stop32_len_clk", 32'(t), 32'd128);
        check("stop32_busy_clear", 32'(tx_busy2), 32'd0);

        repeat (20) @(negedge clk);
        check("frames_total", 32'(frames_seen), 32'd7);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
